// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: synchronizes the keyboard pins, decodes
// 11-bit frames (start, 8 data LSB first, odd parity, stop) and reports the
// received byte or the error that spoiled it.
module ps2_receiver #(
  parameter int unsigned TIMEOUT_COUNT = 2000,
  parameter int unsigned BIT_WIDTH     = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       inhibit,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       reset_required
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [BIT_WIDTH-1:0] TMO_LAST = BIT_WIDTH'(TIMEOUT_COUNT - 1);
  localparam logic [BYTE_W-1:0]    BAT_OK   = 8'hAA;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic clk_s1, clk_s2, clk_hist;
  logic dat_s1, dat_s2;
  logic fall_c;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic                 par_q, par_d;
  logic [BIT_WIDTH-1:0] tmo_q, tmo_d;
  logic [BYTE_W-1:0]    data_d;
  logic                 valid_d, perr_d, ferr_d, rr_d;

  // Two-flop synchronizers; clk_hist keeps the previous synchronized clock.
  // Tracking clk_s2 unconditionally means inhibit release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_hist <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall_c = clk_hist & ~clk_s2;

  // Frame state, counters and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      par_q          <= 1'b0;
      tmo_q          <= '0;
      data           <= '0;
      data_valid     <= 1'b0;
      parity_error   <= 1'b0;
      frame_error    <= 1'b0;
      reset_required <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      par_q          <= par_d;
      tmo_q          <= tmo_d;
      data           <= data_d;
      data_valid     <= valid_d;
      parity_error   <= perr_d;
      frame_error    <= ferr_d;
      reset_required <= rr_d;
    end
  end

  // Next-state and next-output decode for one frame.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    data_d    = data;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    rr_d      = 1'b0;

    if (inhibit) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      tmo_d     = '0;
    end else if (state_q == IDLE) begin
      tmo_d = '0;
      if (fall_c) begin
        if (!dat_s2) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end else begin
          ferr_d = 1'b1;
        end
      end
    end else if (fall_c) begin
      tmo_d = '0;
      case (state_q)
        DATA: begin
          shift_d = {dat_s2, shift_q[BYTE_W-1:1]};
          if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          par_d   = dat_s2;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if ((^{shift_q, par_q}) && dat_s2) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            rr_d    = (shift_q == BAT_OK);
          end else begin
            perr_d = ~(^{shift_q, par_q});
            ferr_d = ~dat_s2;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_q >= TMO_LAST) begin
      // Abandon a frame whose clock has stalled.
      ferr_d    = 1'b1;
      state_d   = IDLE;
      bit_cnt_d = '0;
      tmo_d     = '0;
    end else begin
      tmo_d = tmo_q + BIT_WIDTH'(1);
    end
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_COUNT, default 2000, meaning clk cycles without a PS/2 clock falling edge before an open frame is abandoned.
REQ-002 SHALL have parameter BIT_WIDTH, default 11, meaning width of the timeout counter; it must hold TIMEOUT_COUNT.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ps2_clk  input  1  raw keyboard clock pin, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw keyboard data pin, asynchronous to clk.
REQ-007 SHALL have port inhibit  input  1  high while the host pulls ps2_clk low (ps2_clk_pulldown from the reset-response stage).
REQ-008 SHALL have port data  output  8  last correctly received byte.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse per good frame.
REQ-010 SHALL have port parity_error  output  1  one-cycle pulse for a frame with bad odd parity.
REQ-011 SHALL have port frame_error  output  1  one-cycle pulse for bad start bit, bad stop bit or timeout.
REQ-012 SHALL have port reset_required  output  1  one-cycle pulse when a good frame carries 0xAA; drives the reset-response stage.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through separate two-flop synchronizers; a third ps2_clk flop provides edge history.
REQ-014 SHALL detect a falling edge when the history flop is 1 and synchronized ps2_clk is 0; raw pin to edge detect is 2 cycles.
REQ-015 SHALL sample synchronized ps2_data only in a cycle where a falling edge is detected.
REQ-016 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: edge with data 0 -> DATA, bit count 0, timeout counter cleared; edge with data 1 -> frame_error pulse, stay IDLE.
REQ-018 DATA: each edge shifts the bit in LSB first; after the 8th bit -> PARITY.
REQ-019 PARITY: edge captures parity bit -> STOP; frame parity good when data bits plus parity bit contain an odd number of ones.
REQ-020 STOP: edge evaluates stop bit (must be 1) and parity, then -> IDLE.
REQ-021 Good frame (parity good, stop 1): data updated and data_valid pulsed one cycle after the stop-edge detect cycle; raw pin to data_valid is 3 cycles.
REQ-022 reset_required SHALL pulse in the same cycle as data_valid if and only if the byte is 0xAA.
REQ-023 Bad parity SHALL pulse parity_error; stop bit 0 SHALL pulse frame_error; both pulse together if both are wrong; on any error, data holds its previous value and data_valid stays 0.
REQ-024 The timeout counter SHALL increment every cycle outside IDLE, clear on every falling edge, and never wrap; reaching TIMEOUT_COUNT pulses frame_error and forces IDLE.
REQ-025 While inhibit is high: force IDLE, clear bit and timeout counters, ignore edges, pulse nothing; when inhibit falls, the history flop is reloaded from the synchronizer so the release is not seen as an edge.
REQ-026 All pulse outputs SHALL be registered and high for exactly one cycle per event.

Reset
REQ-027 On rst: state IDLE, counters 0, data 0x00, data_valid, parity_error, frame_error and reset_required 0, all synchronizer and history flops 1 (idle bus).
REQ-028 rst mid-frame SHALL discard the partial frame with no pulses; the next frame is received normally.
REQ-029 rst SHALL take priority over inhibit and edge events in the same cycle.

Verification
REQ-030 Frame 0xAA, parity 1, stop 1 -> data=0xAA, data_valid and reset_required high for one cycle, 3 cycles after the stop falling edge.
REQ-031 Frame 0x1C, parity 0 -> data=0x1C, data_valid one cycle, reset_required 0.
REQ-032 Frame 0x1C, parity 1 -> parity_error one cycle, data_valid 0, data unchanged.
REQ-033 Frame 0xFA, parity 1, stop 0 -> frame_error one cycle, no data_valid.
REQ-034 Four data bits then idle TIMEOUT_COUNT cycles -> frame_error one cycle, then a full 0xFA frame -> data=0xFA, data_valid.
REQ-035 inhibit raised after 5 bits, then released -> no pulses, IDLE; a subsequent 0xAA frame -> reset_required; repeat with rst mid-frame -> same outcome.
